// File: rtl/pipe_pkg.sv
// Shared definitions for the IF -> ID -> EX pipeline.
// Contents: the instruction word layout, opcode constants, the fetch state
// encoding and a helper that extracts the opcode field of a word.
package pipe_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 20;

  // Instruction word layout: {opcode[19:16], opA[15:8], opB[7:0]}
  localparam int OP_MSB = 19;
  localparam int OP_LSB = 16;
  localparam int A_MSB  = 15;
  localparam int A_LSB  = 8;
  localparam int B_MSB  = 7;
  localparam int B_LSB  = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_CMP  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_t;

  function automatic logic [3:0] get_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// IF/ID handshake bundle carrying a fetched instruction to the decode stage.
// Signals:
//   out_valid  register holds an instruction (driven by fetch)
//   out_ready  decode accepts the instruction this cycle (driven by decode)
//   out_instr  fetched instruction word
//   out_pc     address the word was fetched from
// Modports: master = fetch side, slave = decode side.
interface fetch_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 20
);

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the IF stage.
// Owns the PC, addresses a combinational instruction ROM and loads each word
// into the IF/ID register, which is offered to decode on a valid/ready bus.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           pulse that begins (or restarts) fetch from START_ADDR
//   imem_addr       ROM address, always equal to the PC
//   imem_instr      ROM data for imem_addr, same cycle
//   redirect_valid  flush the held word and jump to redirect_addr (RUN only)
//   redirect_addr   redirect target; targets >= PROG_LEN end the program
//   if_id           IF/ID handshake bundle (master side)
//   busy            fetch is running
//   done            program ended and the IF/ID register has drained
module fetch_ctrl #(
  parameter int         ADDR_W     = 8,
  parameter int         INSTR_W    = 20,
  parameter int         PROG_LEN   = 8,
  parameter int         START_ADDR = 0,
  parameter logic [3:0] HALT_OP    = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_instr,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_addr,
  fetch_ctrl_if.master        if_id,
  output logic                busy,
  output logic                done
);

  import pipe_pkg::*;

  // One extra bit so PROG_LEN == 2**ADDR_W is representable in comparisons.
  localparam int                CMP_W   = ADDR_W + 1;
  localparam logic [CMP_W-1:0]  LEN     = CMP_W'(PROG_LEN);
  localparam logic [CMP_W-1:0]  LAST_PC = CMP_W'(PROG_LEN - 1);
  localparam logic [ADDR_W-1:0] START   = ADDR_W'(START_ADDR);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic               advance;

  assign advance = (state_q == ST_RUN) && (!valid_q || if_id.out_ready);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case can leave one unassigned and infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    out_pc_d = out_pc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = START;
        end
      end

      ST_RUN: begin
        if (redirect_valid) begin
          // Flush wins over everything else in RUN, held word is dropped.
          valid_d = 1'b0;
          if ({1'b0, redirect_addr} < LEN) pc_d = redirect_addr;
          else                             state_d = ST_DONE;
        end else if (advance) begin
          if (get_op(imem_instr) == HALT_OP) begin
            // Advance implies any held word is consumed now, so the
            // register empties.
            state_d = ST_DONE;
            valid_d = 1'b0;
          end else begin
            instr_d  = imem_instr;
            out_pc_d = pc_q;
            valid_d  = 1'b1;
            // PC parks on the last word rather than stepping past the program.
            if ({1'b0, pc_q} == LAST_PC) state_d = ST_DONE;
            else                         pc_d    = pc_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = START;
          valid_d = 1'b0;
        end else if (valid_q && if_id.out_ready) begin
          valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= START;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      out_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      out_pc_q <= out_pc_d;
    end
  end

  assign imem_addr       = pc_q;
  assign if_id.out_valid = valid_q;
  assign if_id.out_instr = instr_q;
  assign if_id.out_pc    = out_pc_q;
  assign busy            = (state_q == ST_RUN);
  assign done            = (state_q == ST_DONE) && !valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios push the words they
// expect decode to receive; a negedge monitor pops and compares on every
// handshake.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  imem_addr;
  logic [19:0] imem_instr;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        busy;
  logic        done;

  logic [19:0] rom [256];
  logic [19:0] wd  [8];
  logic [27:0] exp_q [$];

  int checks   = 0;
  int failures = 0;

  fetch_ctrl_if #(.ADDR_W(8), .INSTR_W(20)) bus ();

  fetch_ctrl #(
    .ADDR_W(8), .INSTR_W(20), .PROG_LEN(8), .START_ADDR(0), .HALT_OP(4'hF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .if_id          (bus.master),
    .busy           (busy),
    .done           (done)
  );

  assign imem_instr = rom[imem_addr];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {12'b0, bus.out_instr}, 32'hFFFF_FFFF);
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        check("out_instr", {12'b0, bus.out_instr}, {12'b0, e[27:8]});
        check("out_pc", {24'b0, bus.out_pc}, {24'b0, e[7:0]});
      end
    end
    if (busy === 1'b1) check("imem_addr_range", 32'(imem_addr > 8'd7), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx);
    exp_q.push_back({wd[idx], 8'(idx)});
  endtask

  task automatic push_all();
    for (int i = 0; i < 8; i++) push(i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valid", {31'b0, bus.out_valid}, 0);
    check("rst_instr", {12'b0, bus.out_instr}, 0);
    check("rst_pc", {24'b0, bus.out_pc}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_addr", {24'b0, imem_addr}, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'b0, done}, 1);
  endtask

  task automatic q_empty(input string name);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    bus.out_ready = 1'b0;
    wd[0] = 20'h00503; wd[1] = 20'h10A03; wd[2] = 20'h2F00F; wd[3] = 20'h30102;
    wd[4] = 20'h40304; wd[5] = 20'h50205; wd[6] = 20'h60701; wd[7] = 20'h7F003;
    for (int i = 0; i < 256; i++) rom[i] = (i < 8) ? wd[i] : 20'h0;
    tick();

    // 1: full run with out_ready held high
    do_reset();
    bus.out_ready = 1'b1;
    push_all();
    pulse_start();
    check("t1_busy", {31'b0, busy}, 1);
    check("t1_no_fetch_on_start", {31'b0, bus.out_valid}, 0);
    tick();
    check("t1_first_valid", {31'b0, bus.out_valid}, 1);
    check("t1_first_pc", {24'b0, bus.out_pc}, 0);
    wait_done("t1_done", 40);
    q_empty("t1_drained");

    // 2: backpressure while word 1 is held
    do_reset();
    bus.out_ready = 1'b1;
    push_all();
    pulse_start();
    tick();
    tick();
    check("t2_held_pc", {24'b0, bus.out_pc}, 1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_stall_valid", {31'b0, bus.out_valid}, 1);
      check("t2_stall_instr", {12'b0, bus.out_instr}, 32'h10A03);
      check("t2_stall_pc", {24'b0, bus.out_pc}, 1);
      check("t2_stall_addr", {24'b0, imem_addr}, 2);
    end
    bus.out_ready = 1'b1;
    wait_done("t2_done", 40);
    q_empty("t2_drained");

    // 3a: redirect to 5 while word 2 is held
    do_reset();
    bus.out_ready = 1'b1;
    push(0); push(1); push(5); push(6); push(7);
    pulse_start();
    tick(); tick(); tick();
    check("t3_held_pc", {24'b0, bus.out_pc}, 2);
    bus.out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 8'd5;
    tick();
    redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("t3_flush_valid", {31'b0, bus.out_valid}, 0);
    check("t3_flush_addr", {24'b0, imem_addr}, 5);
    tick();
    check("t3_target_valid", {31'b0, bus.out_valid}, 1);
    check("t3_target_pc", {24'b0, bus.out_pc}, 5);
    wait_done("t3_done", 40);
    q_empty("t3_drained");

    // 3b: redirect past the program ends it
    do_reset();
    bus.out_ready = 1'b1;
    push(0);
    pulse_start();
    tick();
    redirect_valid = 1'b1;
    redirect_addr = 8'd8;
    tick();
    redirect_valid = 1'b0;
    check("t3b_done", {31'b0, done}, 1);
    check("t3b_busy", {31'b0, busy}, 0);
    q_empty("t3b_drained");

    // 4: HALT at address 3
    rom[3] = 20'hF0000;
    do_reset();
    bus.out_ready = 1'b1;
    push(0); push(1); push(2);
    pulse_start();
    wait_done("t4_done", 40);
    q_empty("t4_drained");
    check("t4_valid", {31'b0, bus.out_valid}, 0);
    rom[3] = wd[3];

    // 5: reset mid-run while pc 4 is presented, then replay
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(i);
    pulse_start();
    repeat (5) tick();
    check("t5_pc4_valid", {31'b0, bus.out_valid}, 1);
    check("t5_pc4", {24'b0, bus.out_pc}, 4);
    do_reset();
    q_empty("t5_pre_replay");
    push_all();
    pulse_start();
    wait_done("t5_done", 40);
    q_empty("t5_drained");

    // 6: restart from DONE, with a stray start mid-run
    push_all();
    pulse_start();
    check("t6_busy", {31'b0, busy}, 1);
    repeat (3) tick();
    pulse_start();
    wait_done("t6_done", 40);
    q_empty("t6_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
